// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode, funct, ALU op and access-size constants shared by decode, stage and ALU
package riscv_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int REGADDR_DEF = 5;

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_ADDI = 3'b110
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    op_a_pc;
    logic    op_b_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    illegal;
  } ctrl_t;

  function automatic logic load_size_ok(input logic [2:0] f3);
    return (f3 == SZ_D) || (f3 == SZ_W) || (f3 == SZ_WU) || (f3 == SZ_H) || (f3 == SZ_HU);
  endfunction

  function automatic logic store_size_ok(input logic [2:0] f3);
    return (f3 == SZ_D) || (f3 == SZ_W) || (f3 == SZ_H);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct3/funct7 to ALU op, operand selects and controls
import riscv_pkg::*;

module alu_op_decode (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl
);

  // Unsupported encodings raise only the illegal flag; every other control stays 0.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ARITH: begin
        ctrl.reg_write = 1'b1;
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_SUB) ctrl.alu_op = ALU_SUB;
            else                  ctrl.alu_op = ALU_ADD;
          end
          F3_AND: ctrl.alu_op = ALU_AND;
          F3_OR:  ctrl.alu_op = ALU_OR;
          F3_XOR: ctrl.alu_op = ALU_XOR;
          F3_SLT: ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.reg_write = 1'b0;
            ctrl.illegal   = 1'b1;
          end
        endcase
      end
      OP_IMM: begin
        if (funct3 == F3_ADDI) begin
          ctrl.alu_op    = ALU_ADDI;
          ctrl.op_b_imm  = 1'b1;
          ctrl.reg_write = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (load_size_ok(funct3)) begin
          ctrl.op_b_imm  = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.reg_write = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (store_size_ok(funct3)) begin
          ctrl.op_b_imm  = 1'b1;
          ctrl.mem_write = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BNE) begin
          ctrl.alu_op = ALU_SUB;
          ctrl.branch = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl.op_a_pc   = 1'b1;
        ctrl.op_b_imm  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        ctrl.op_b_imm  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU-control decode and operand select
// Optional EX/MEM and MEM/WB operand forwarding is built when FORWARDING_EN is defined.
import riscv_pkg::*;

module id_ex_stage #(
  parameter int XLEN    = 64,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic [6:0]         id_funct7,
  input  logic [REGADDR-1:0] id_rs1_addr,
  input  logic [REGADDR-1:0] id_rs2_addr,
  input  logic [REGADDR-1:0] id_rd_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_pc,
  input  logic               exm_reg_write,
  input  logic [REGADDR-1:0] exm_rd_addr,
  input  logic [XLEN-1:0]    exm_result,
  input  logic               mwb_reg_write,
  input  logic [REGADDR-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0]    mwb_result,
  output logic               ex_valid,
  output logic [2:0]         ex_alu_op,
  output logic [XLEN-1:0]    ex_op_a,
  output logic [XLEN-1:0]    ex_op_b,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [REGADDR-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic [2:0]         ex_mem_size,
  output logic [XLEN-1:0]    ex_pc,
  output logic               ex_illegal
);

  typedef struct packed {
    logic               valid;
    ctrl_t              ctrl;
    logic [REGADDR-1:0] rs1_addr;
    logic [REGADDR-1:0] rs2_addr;
    logic [REGADDR-1:0] rd_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [2:0]         mem_size;
  } stage_t;

  ctrl_t  id_ctrl;
  stage_t id_stage;
  stage_t q;

  alu_op_decode u_decode (
    .opcode (id_opcode),
    .funct3 (id_funct3),
    .funct7 (id_funct7),
    .ctrl   (id_ctrl)
  );

  // An all-zero stage_t is the bubble; id_valid=0 loads one.
  always_comb begin
    id_stage = '0;
    if (id_valid) begin
      id_stage.valid          = 1'b1;
      id_stage.ctrl           = id_ctrl;
      id_stage.ctrl.reg_write = id_ctrl.reg_write && (id_rd_addr != '0);
      id_stage.rs1_addr       = id_rs1_addr;
      id_stage.rs2_addr       = id_rs2_addr;
      id_stage.rd_addr        = id_rd_addr;
      id_stage.rs1_data       = id_rs1_data;
      id_stage.rs2_data       = id_rs2_data;
      id_stage.imm            = id_imm;
      id_stage.pc             = id_pc;
      id_stage.mem_size       = id_ctrl.illegal ? 3'b000 : id_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= id_stage;
    end
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef FORWARDING_EN
  // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards.
  assign rs1_val = (exm_reg_write && (exm_rd_addr == q.rs1_addr) && (q.rs1_addr != '0)) ? exm_result :
                   (mwb_reg_write && (mwb_rd_addr == q.rs1_addr) && (q.rs1_addr != '0)) ? mwb_result :
                   q.rs1_data;
  assign rs2_val = (exm_reg_write && (exm_rd_addr == q.rs2_addr) && (q.rs2_addr != '0)) ? exm_result :
                   (mwb_reg_write && (mwb_rd_addr == q.rs2_addr) && (q.rs2_addr != '0)) ? mwb_result :
                   q.rs2_data;
`else
  assign rs1_val = q.rs1_data;
  assign rs2_val = q.rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{exm_reg_write, exm_rd_addr, exm_result,
                        mwb_reg_write, mwb_rd_addr, mwb_result,
                        q.rs1_addr, q.rs2_addr};
`endif

  assign ex_valid      = q.valid;
  assign ex_alu_op     = q.ctrl.alu_op;
  assign ex_op_a       = q.ctrl.op_a_pc ? q.pc : rs1_val;
  assign ex_op_b       = q.ctrl.op_b_imm ? q.imm : rs2_val;
  assign ex_store_data = rs2_val;
  assign ex_rd_addr    = q.rd_addr;
  assign ex_reg_write  = q.ctrl.reg_write;
  assign ex_mem_read   = q.ctrl.mem_read;
  assign ex_mem_write  = q.ctrl.mem_write;
  assign ex_branch     = q.ctrl.branch;
  assign ex_jump       = q.ctrl.jump;
  assign ex_mem_size   = q.mem_size;
  assign ex_pc         = q.pc;
  assign ex_illegal    = q.ctrl.illegal;

endmodule
